// File: rtl/ramio_arbiter_pkg.sv
// ramio_arbiter_pkg: shared FSM states and request record for the ramio arbiter
package ramio_arbiter_pkg;
  localparam int MaxAddressBitWidth = 64;
  typedef enum logic [1:0] {Idle, Issue, Wait} state_e;
  typedef struct packed {
    logic [1:0] write_type;
    logic [2:0] read_type;
    logic [MaxAddressBitWidth-1:0] address;
    logic [31:0] data_in;
  } req_t;
endpackage

// File: rtl/ramio_arbiter_request.sv
// ramio_arbiter_request: one-deep capture buffer holding a single requester's pending request
module ramio_arbiter_request
  import ramio_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic capture,
  input  logic clear,
  input  req_t req,
  output logic pending,
  output req_t req_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      req_q <= '0;
    end else begin
      if (capture) req_q <= req;
      pending <= capture | (pending & ~clear);
    end
  end
endmodule

// File: rtl/ramio_arbiter.sv
// ramio_arbiter: round-robin arbiter sharing one ramio port between two buffered requesters
module ramio_arbiter
  import ramio_arbiter_pkg::*;
#(
  parameter int AddressBitWidth = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_enable,
  input  logic [1:0] m0_write_type,
  input  logic [2:0] m0_read_type,
  input  logic [AddressBitWidth-1:0] m0_address,
  input  logic [31:0] m0_data_in,
  output logic [31:0] m0_data_out,
  output logic m0_data_out_ready,
  output logic m0_busy,
  input  logic m1_enable,
  input  logic [1:0] m1_write_type,
  input  logic [2:0] m1_read_type,
  input  logic [AddressBitWidth-1:0] m1_address,
  input  logic [31:0] m1_data_in,
  output logic [31:0] m1_data_out,
  output logic m1_data_out_ready,
  output logic m1_busy,
  output logic ramio_enable,
  output logic [1:0] ramio_write_type,
  output logic [2:0] ramio_read_type,
  output logic [AddressBitWidth-1:0] ramio_address,
  output logic [31:0] ramio_data_in,
  input  logic [31:0] ramio_data_out,
  input  logic ramio_data_out_ready,
  input  logic ramio_busy
);
  state_e state, state_n;
  logic grant, grant_n, last_grant, last_grant_n, ready_seen, ready_seen_n;
  logic pending0, pending1, clear0, clear1, winner, done, active;
  req_t req0_d, req1_d, req0_q, req1_q, ramio_q, ramio_q_n;
  assign req0_d = '{write_type: m0_write_type, read_type: m0_read_type,
                    address: MaxAddressBitWidth'(m0_address), data_in: m0_data_in};
  assign req1_d = '{write_type: m1_write_type, read_type: m1_read_type,
                    address: MaxAddressBitWidth'(m1_address), data_in: m1_data_in};
  assign active = state != Idle;
  assign m0_busy = pending0 | (~grant & active);
  assign m1_busy = pending1 | (grant & active);
  ramio_arbiter_request u_req0 (
    .clk(clk), .rst(rst), .capture(m0_enable & ~m0_busy), .clear(clear0),
    .req(req0_d), .pending(pending0), .req_q(req0_q)
  );
  ramio_arbiter_request u_req1 (
    .clk(clk), .rst(rst), .capture(m1_enable & ~m1_busy), .clear(clear1),
    .req(req1_d), .pending(pending1), .req_q(req1_q)
  );
  // a lone pending request wins outright; a tie goes to whoever was not served last
  assign winner = (pending0 & pending1) ? ~last_grant : pending1;
  assign done = ~ramio_busy & (ramio_q.read_type == 3'd0 | ready_seen | ramio_data_out_ready);
  always_comb begin
    state_n = state;
    grant_n = grant;
    last_grant_n = last_grant;
    ready_seen_n = ready_seen;
    ramio_q_n = ramio_q;
    clear0 = 1'b0;
    clear1 = 1'b0;
    case (state)
      Idle: if ((pending0 | pending1) & ~ramio_busy) begin
        state_n = Issue;
        grant_n = winner;
        ramio_q_n = winner ? req1_q : req0_q;
        clear0 = ~winner;
        clear1 = winner;
      end
      Issue: state_n = Wait;
      Wait: begin
        ready_seen_n = ready_seen | ramio_data_out_ready;
        if (done) begin
          state_n = Idle;
          last_grant_n = grant;
          ready_seen_n = 1'b0;
        end
      end
      default: state_n = Idle;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= Idle;
      grant <= 1'b0;
      last_grant <= 1'b1;
      ready_seen <= 1'b0;
      ramio_q <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      last_grant <= last_grant_n;
      ready_seen <= ready_seen_n;
      ramio_q <= ramio_q_n;
    end
  end
  assign ramio_enable = state == Issue;
  assign ramio_write_type = ramio_q.write_type;
  assign ramio_read_type = ramio_q.read_type;
  assign ramio_address = ramio_q.address[AddressBitWidth-1:0];
  assign ramio_data_in = ramio_q.data_in;
  assign m0_data_out = ramio_data_out;
  assign m1_data_out = ramio_data_out;
  assign m0_data_out_ready = ramio_data_out_ready & ~grant & active;
  assign m1_data_out_ready = ramio_data_out_ready & grant & active;
  // the record is sized for the widest address; upper bits are always zero here
  if (AddressBitWidth < MaxAddressBitWidth) begin : g_addr_hi
    logic unused_address_hi;
    assign unused_address_hi = ^ramio_q.address[MaxAddressBitWidth-1:AddressBitWidth];
  end
endmodule

// File: doc/ramio_arbiter.md
RAMIO_ARBITER -- requirements
Module: ramio_arbiter

Interface
REQ-001 SHALL have parameter AddressBitWidth, default 32, meaning the width of the ramio address path.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 SHALL have, per requester N in {0,1}:
- mN_enable, input, 1: request strobe.
- mN_write_type, input, 2: 0 means no write.
- mN_read_type, input, 3: 0 means no read.
- mN_address, input, AddressBitWidth.
- mN_data_in, input, 32.
- mN_data_out, output, 32.
- mN_data_out_ready, output, 1.
- mN_busy, output, 1.
REQ-006 SHALL have, on the ramio side:
- ramio_enable, output, 1.
- ramio_write_type, output, 2.
- ramio_read_type, output, 3.
- ramio_address, output, AddressBitWidth.
- ramio_data_in, output, 32.
- ramio_data_out, input, 32.
- ramio_data_out_ready, input, 1.
- ramio_busy, input, 1.

Function
REQ-007 SHALL capture a request for requester N (type, address and data fields) into a per-requester buffer and set pending_N when mN_enable=1 and mN_busy=0.
REQ-008 SHALL ignore and drop mN_enable while mN_busy=1; no state change results.
REQ-009 SHALL drive mN_busy = pending_N OR (grant=N AND state!=Idle), derived from registers only.
REQ-010 SHALL implement a state machine with the states Idle, Issue and Wait.
REQ-011 In Idle with at least one pending request and ramio_busy=0, SHALL pick a winner, register grant and the winner's fields onto the ramio outputs, clear the winner's pending bit, and go to Issue.
REQ-012 In Idle with ramio_busy=1, SHALL stay in Idle and grant nothing.
REQ-013 SHALL choose the winner by round-robin when both requests are pending: the requester not equal to last_grant wins.
REQ-014 SHALL grant a single pending request regardless of last_grant.
REQ-015 In Issue, SHALL hold ramio_enable=1 for exactly one cycle, then go to Wait unconditionally; ramio_busy is not sampled in Issue.
REQ-016 In Wait, SHALL hold ramio_enable=0 and all ramio fields stable.
REQ-017 In Wait, SHALL set ready_seen when ramio_data_out_ready=1.
REQ-018 SHALL complete a transaction in Wait when ramio_busy=0 AND (read_type=0 OR ready_seen OR ramio_data_out_ready).
REQ-019 On completion, SHALL go to Idle, set last_grant=grant and clear ready_seen.
REQ-020 SHALL drive mN_data_out = ramio_data_out for both requesters (shared bus).
REQ-021 SHALL drive mN_data_out_ready = ramio_data_out_ready AND grant=N AND state!=Idle.
REQ-022 Minimum latency, with ramio idle:
- mN_enable at cycle t.
- pending at t+1.
- ramio_enable high at t+2.
- Completion no earlier than t+3.
- mN_busy low the cycle after completion.
REQ-023 SHALL allow a requester whose request completes to re-request in the cycle its busy is low, and that request SHALL be buffered even while the other requester is granted.
REQ-024 SHALL treat a request with write_type=0 and read_type=0 as a valid transaction and forward it unchanged.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set:
- state=Idle.
- pending_0 and pending_1 = 0.
- grant=0.
- last_grant=1, so requester 0 wins first.
- ready_seen=0.
- ramio_enable=0.
- All ramio field outputs = 0.
REQ-026 SHALL, for rst asserted mid-transaction, abandon the transaction without completing it and drop both buffered requests; mN_busy=0 the cycle after reset.
REQ-027 SHALL hold all outputs at their reset values for as long as rst=1.

Structure
REQ-028 SHALL place the state enum (Idle, Issue, Wait) and a request struct (write_type, read_type, address, data_in) in the shared package ramio_arbiter_pkg.
REQ-029 SHALL implement the per-requester capture buffer (capture, pending, clear) as sub-module ramio_arbiter_request, instantiated twice.

Verification
REQ-030 Single read: m0 read_type=2 address=0x0000_FFCC with ramio completing 3 cycles after enable, returning data_out=0x1234_5678 -> ramio_enable is a single pulse at t+2, m0_data_out_ready=1 with 0x1234_5678, m1_data_out_ready stays 0, m0_busy=0 the cycle after completion.
REQ-031 Simultaneous requests after reset: m0 and m1 both write in the same cycle -> m0 is issued first, m1 follows; ramio_address shows m0's address then m1's; each ramio_enable lasts one cycle.
REQ-032 Fairness: both requesters re-request continuously for 6 transactions -> grant order is 0,1,0,1,0,1.
REQ-033 Read ready early: ramio_data_out_ready pulses while ramio_busy=1, and busy falls 2 cycles later -> completion occurs on the cycle busy falls, and m0 stays busy until then.
REQ-034 Drop while busy: m1_enable is pulsed while m1_busy=1 -> no extra ramio transaction; ramio_enable pulse count equals the number of accepted requests.
REQ-035 Reset in Wait: rst asserted for 1 cycle with m1 pending -> state=Idle, both busy outputs 0, ramio_enable 0, and no grant issued afterwards without a new request.
